// File: rtl/mac_log_pkg.sv
// Shared types and sizing helpers for the log-domain MAC and its sequencer.
package mac_log_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT
    } seq_state_t;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int PROD_WIDTH     = 2**DATA_WIDTH_DEF;

    // Headroom of 6 bits lets 64 full-scale products accumulate without wrap.
    function automatic int default_acc_width(input int dw);
        return 2**dw + 6;
    endfunction

endpackage

// File: rtl/mac_log_pure.sv
// Log-domain MAC: product = +/-2^(ew+ea), one product register then accumulate.
// A beat accepted on en shows up in acc_out two cycles later.
module mac_log_pure
    import mac_log_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] weight,
    input  logic [DATA_WIDTH-1:0] act,
    output logic [ACC_WIDTH-1:0]  acc_out
);

    localparam int PW = 2**DATA_WIDTH;
    localparam int EW = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_exp_sum;
    logic [PW-1:0]         w_mag;
    logic [PW-1:0]         w_prod;
    logic                  r_vld;
    logic [PW-1:0]         r_prod;
    logic [ACC_WIDTH-1:0]  r_acc;

    // Largest exponent sum is 2^DATA_WIDTH-2, so the magnitude always fits signed in PW bits.
    assign w_exp_sum = {1'b0, weight[EW-1:0]} + {1'b0, act[EW-1:0]};
    assign w_mag     = PW'(1) << w_exp_sum;
    assign w_prod    = (weight[DATA_WIDTH-1] ^ act[DATA_WIDTH-1]) ? (~w_mag + 1'b1) : w_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_vld  <= en;
            r_prod <= w_prod;
            if (r_vld)
                r_acc <= r_acc + {{(ACC_WIDTH-PW){r_prod[PW-1]}}, r_prod};
        end
    end

    assign acc_out = r_acc;

endmodule

// File: rtl/mac_log_seq.sv
// Sequencer for one log-domain MAC: clear, stream N operand pairs, drain the
// MAC pipeline and hand the accumulator out on a valid/ready result port.
module mac_log_seq
    import mac_log_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH),
    parameter int LEN_W      = 8,
    parameter int MAC_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      vec_len,
    output logic                  busy,
    output logic                  err_zero_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_weight,
    input  logic [DATA_WIDTH-1:0] in_act,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_weight,
    output logic [DATA_WIDTH-1:0] mac_act,
    input  logic [ACC_WIDTH-1:0]  mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
);

    generate
        if (MAC_LAT < 1) begin : g_bad_mac_lat
            $error("mac_log_seq: MAC_LAT must be at least 1");
        end
    endgenerate

    localparam int DCW = $clog2(MAC_LAT + 1);

    seq_state_t           r_state, w_next;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_remain;
    logic [DCW-1:0]       r_drain;
    logic                 r_res_valid;
    logic [ACC_WIDTH-1:0] r_res_data;
    logic                 r_err;

    logic w_hs, w_res_hs, w_len_zero, w_cmd_window, w_last_drain;

    assign w_hs         = in_valid & in_ready;
    assign w_res_hs     = r_res_valid & res_ready;
    assign w_len_zero   = (vec_len == '0);
    // A command is only taken in IDLE or in the very cycle the result leaves.
    assign w_cmd_window = (r_state == S_IDLE) | ((r_state == S_OUT) & w_res_hs);
    assign w_last_drain = (r_drain == DCW'(MAC_LAT - 1));

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        mac_en   = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !w_len_zero) w_next = S_CLEAR;
            S_CLEAR: w_next = S_RUN;
            S_RUN: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                if (in_valid && r_remain == LEN_W'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: if (w_last_drain) w_next = S_OUT;
            S_OUT:   if (w_res_hs) w_next = (start && !w_len_zero) ? S_CLEAR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_remain    <= '0;
            r_drain     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_cmd_window & start & w_len_zero;
            if (w_cmd_window & start & !w_len_zero)
                r_len <= vec_len;
            case (r_state)
                S_CLEAR: begin
                    r_remain <= r_len;
                    r_drain  <= '0;
                end
                S_RUN: if (w_hs) r_remain <= r_remain - 1'b1;
                S_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (w_last_drain) begin
                        r_res_data  <= mac_out;
                        r_res_valid <= 1'b1;
                    end
                end
                S_OUT: if (w_res_hs) r_res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign err_zero_len = r_err;
    assign mac_clr      = reset | (r_state == S_CLEAR);
    assign mac_weight   = in_weight;
    assign mac_act      = in_act;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;

endmodule
